// File: rtl/gamepad_pmod_tx.sv
// Gamepad PMOD serial transmitter: snapshots two 12-bit button words and shifts them out MSB-first
// with a mid-bit rising pmod_clk. A frame then ends with a latch pulse. Busy lasts (NUM_BITS+1)*2*CLK_DIV cycles; start is ignored while busy.
module gamepad_pmod_tx #(
   parameter int CLK_DIV  = 4,
   parameter int NUM_BITS = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] buttons_a,
   input  logic [11:0] buttons_b,
   input  logic        present_a,
   input  logic        present_b,
   output logic        pmod_clk,
   output logic        pmod_data,
   output logic        pmod_latch,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH
   } state_t;

   localparam int PH_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
   localparam int BC_W = $clog2(NUM_BITS);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(NUM_BITS - 1);

   state_t              state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
   logic [NUM_BITS-1:0] shreg_q, shreg_d;
   logic                clk_q, clk_d;
   logic                data_q, data_d;
   logic                latch_q, latch_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [11:0] word_a, word_b;

   // An absent controller reads as all buttons released.
   assign word_a = present_a ? buttons_a : 12'hFFF;
   assign word_b = present_b ? buttons_b : 12'hFFF;

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      clk_d    = 1'b0;
      data_d   = data_q;
      latch_d  = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            data_d = 1'b0;
            if (start) begin
               shreg_d  = {word_a, word_b};
               data_d   = word_a[11];
               phase_d  = '0;
               bitcnt_d = '0;
               busy_d   = 1'b1;
               state_d  = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (bitcnt_q == BC_LAST) begin
                  data_d  = 1'b0;
                  latch_d = 1'b1;
                  state_d = ST_LATCH;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
                  shreg_d  = {shreg_q[NUM_BITS-2:0], 1'b0};
                  data_d   = shreg_q[NUM_BITS-2];
               end
            end else begin
               phase_d = phase_q + 1'b1;
               // Clock goes high for the second half of the bit, so the
               // receiver's rising edge lands CLK_DIV cycles after data moves.
               clk_d   = (phase_d >= PH_HALF);
            end
         end

         ST_LATCH: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               phase_d = phase_q + 1'b1;
               latch_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         phase_q  <= '0;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         clk_q    <= 1'b0;
         data_q   <= 1'b0;
         latch_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         clk_q    <= clk_d;
         data_q   <= data_d;
         latch_q  <= latch_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign pmod_clk   = clk_q;
   assign pmod_data  = data_q;
   assign pmod_latch = latch_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Directed bench for gamepad_pmod_tx at CLK_DIV=2 with a receiver model on the serial pins.
module tb_gamepad_pmod_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] buttons_a = 12'h000;
   logic [11:0] buttons_b = 12'h000;
   logic        present_a = 1'b1;
   logic        present_b = 1'b1;
   logic        pmod_clk, pmod_data, pmod_latch, busy, done;

   gamepad_pmod_tx #(.CLK_DIV(2), .NUM_BITS(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .buttons_a (buttons_a),
      .buttons_b (buttons_b),
      .present_a (present_a),
      .present_b (present_b),
      .pmod_clk  (pmod_clk),
      .pmod_data (pmod_data),
      .pmod_latch(pmod_latch),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Receiver model and activity counters, sampled on the falling edge.
   int          cyc = 0, rises = 0, latch_cyc = 0, latch_rises = 0;
   int          busy_cyc = 0, done_cnt = 0, overlap = 0;
   int          stable = 0, setup = 0, min_setup = 99;
   logic [23:0] cap = '0, frame_cap = '0;
   logic        prev_pclk = 1'b0, prev_data = 1'b0, prev_latch = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (pmod_clk && !prev_pclk) begin
         rises = rises + 1;
         cap = {cap[22:0], pmod_data};
         setup = (pmod_data != prev_data) ? 0 : stable;
         if (setup < min_setup) min_setup = setup;
      end
      if (pmod_data != prev_data) stable = 1;
      else stable = stable + 1;
      if (pmod_latch) latch_cyc = latch_cyc + 1;
      if (pmod_latch && !prev_latch) begin
         latch_rises = latch_rises + 1;
         frame_cap = cap;
      end
      if (pmod_latch && pmod_clk) overlap = overlap + 1;
      if (busy) busy_cyc = busy_cyc + 1;
      if (done) done_cnt = done_cnt + 1;
      prev_pclk  = pmod_clk;
      prev_data  = pmod_data;
      prev_latch = pmod_latch;
   end

   int tests = 0, fails = 0;
   int b0, r0, l0, d0, lr0;
   int t1, t2, t3;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap;
      b0 = busy_cyc; r0 = rises; l0 = latch_cyc; d0 = done_cnt; lr0 = latch_rises;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300; i++) begin
         tick;
         if (done === 1'b1) break;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_clk"},   {31'd0, pmod_clk},   32'd0);
      check({tag, "_data"},  {31'd0, pmod_data},  32'd0);
      check({tag, "_latch"}, {31'd0, pmod_latch}, 32'd0);
      check({tag, "_busy"},  {31'd0, busy},       32'd0);
      check({tag, "_done"},  {31'd0, done},       32'd0);
   endtask

   initial begin
      // Reset with start also high: reset wins.
      start = 1'b1;
      tick; tick;
      check_idle_outputs("reset");
      rst = 1'b0; start = 1'b0;
      tick;

      // Basic frame.
      buttons_a = 12'hA5C; buttons_b = 12'h3F1;
      snap;
      pulse_start;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("first_bit", {31'd0, pmod_data}, 32'd1);
      wait_done("basic_done");
      check("basic_busy_at_done", {31'd0, busy}, 32'd0);
      tick;
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("basic_capture", {8'd0, frame_cap}, 32'hA5C3F1);
      check("basic_rises", rises - r0, 32'd24);
      check("basic_latch_cycles", latch_cyc - l0, 32'd4);
      check("basic_busy_cycles", busy_cyc - b0, 32'd100);
      check("basic_done_count", done_cnt - d0, 32'd1);

      // Controller 2 absent.
      buttons_a = 12'h001; buttons_b = 12'h000; present_b = 1'b0;
      pulse_start;
      wait_done("absent_done");
      check("absent_capture", {8'd0, frame_cap}, 32'h001FFF);
      present_b = 1'b1;
      tick;

      // Inputs change at bit 3; the snapshot must hold.
      buttons_a = 12'h800; buttons_b = 12'h000;
      pulse_start;
      repeat (12) tick;
      buttons_a = 12'h000;
      wait_done("snap_done");
      check("snap_msb", {31'd0, frame_cap[23]}, 32'd1);
      check("snap_capture", {8'd0, frame_cap}, 32'h800000);
      tick;

      // Start pulse mid-frame is ignored.
      buttons_a = 12'h5A5; buttons_b = 12'hA5A;
      snap;
      pulse_start;
      repeat (20) tick;
      pulse_start;
      wait_done("busy_start_done");
      repeat (150) tick;
      check("busy_start_done_count", done_cnt - d0, 32'd1);
      check("busy_start_latch_count", latch_rises - lr0, 32'd1);
      check("busy_start_capture", {8'd0, frame_cap}, 32'h5A5A5A);
      check("busy_start_idle", {31'd0, busy}, 32'd0);

      // Reset during bit 10 aborts the frame without a latch.
      buttons_a = 12'hABC; buttons_b = 12'hDEF;
      snap;
      pulse_start;
      repeat (40) tick;
      check("midframe_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1; start = 1'b1;
      tick;
      check_idle_outputs("abort");
      rst = 1'b0; start = 1'b0;
      repeat (20) tick;
      check("abort_no_latch", latch_rises - lr0, 32'd0);
      check("abort_no_done", done_cnt - d0, 32'd0);
      check("abort_idle", {31'd0, busy}, 32'd0);
      snap;
      pulse_start;
      wait_done("after_abort_done");
      check("after_abort_capture", {8'd0, frame_cap}, 32'hABCDEF);
      check("after_abort_rises", rises - r0, 32'd24);
      tick;

      // Start held high: back-to-back frames.
      buttons_a = 12'h123; buttons_b = 12'h456;
      snap;
      start = 1'b1;
      wait_done("cont_done1");
      t1 = cyc;
      wait_done("cont_done2");
      t2 = cyc;
      wait_done("cont_done3");
      t3 = cyc;
      start = 1'b0;
      repeat (10) tick;
      check("cont_spacing12", t2 - t1, 32'd101);
      check("cont_spacing23", t3 - t2, 32'd101);
      check("cont_done_count", done_cnt - d0, 32'd3);
      check("cont_capture", {8'd0, frame_cap}, 32'h123456);
      check("cont_rises", rises - r0, 32'd72);

      check("latch_clk_overlap", overlap, 32'd0);
      check("setup_ge_2", {31'd0, (min_setup >= 2)}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
